// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the WISC-15 pipeline.
//
// Owns the architectural PC. Issues word reads to instruction memory over a
// req/ack handshake and loads the IF/ID pipeline register. Fall-through
// (PC+1) is always the prediction. Redirects come from the next-PC/branch
// logic via flush/next_pc, and stalls come from the hazard unit. Fetch stops
// once a HLT instruction has entered IF/ID.
//
// Parameters:
//   RESET_PC    PC value loaded on reset
//   HLT_OPCODE  instr[15:12] value that marks a halt
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   next_pc        redirect target, sampled only while flush=1
//   flush          squash IF/ID and any in-flight fetch, redirect to next_pc
//   stall          hold IF/ID contents
//   imem_req/addr  fetch request and word address (addr stable while req=1)
//   imem_rdata/ack instruction word and request completion (zero-wait allowed)
//   ifid_instr     IF/ID instruction
//   ifid_pc1       PC+1 of that instruction
//   ifid_valid     IF/ID holds a live instruction
//   pc             current fetch PC
//   halted         fetch is halted
//
// Optional feature (macro IF_PERF_EN): adds perf_fetch_cnt, which counts
// words written into IF/ID, and perf_squash_cnt, which counts fetched words
// that were discarded.

module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] next_pc,
  input  logic        flush,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ack,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc1,
  output logic        ifid_valid,
  output logic [15:0] pc,
  output logic        halted
`ifdef IF_PERF_EN
  ,
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_squash_cnt
`endif
);

  typedef enum logic [1:0] {FETCH, DRAIN, HOLD, HALT} fetchState_e;

  fetchState_e state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] redirectPc_q, redirectPc_d;
  logic [15:0] holdInstr_q, holdInstr_d;
  logic [15:0] ifidInstr_q, ifidInstr_d;
  logic [15:0] ifidPc1_q, ifidPc1_d;
  logic        ifidValid_q, ifidValid_d;

  logic        accept;
  logic [15:0] pcPlus1;
  logic        doLoad;
  logic [15:0] loadWord;

  assign accept  = !stall || !ifidValid_q;
  assign pcPlus1 = pc_q + 16'd1;

  // State register plus all datapath registers of the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      redirectPc_q <= 16'h0000;
      holdInstr_q  <= 16'h0000;
      ifidInstr_q  <= 16'h0000;
      ifidPc1_q    <= 16'h0000;
      ifidValid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redirectPc_q <= redirectPc_d;
      holdInstr_q  <= holdInstr_d;
      ifidInstr_q  <= ifidInstr_d;
      ifidPc1_q    <= ifidPc1_d;
      ifidValid_q  <= ifidValid_d;
    end
  end

  // Next-state logic. Any flush clears ifid_valid, which gives flush priority
  // over stall. A word arriving while IF/ID is stalled is parked in holdInstr
  // so that it is neither lost nor fetched a second time.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redirectPc_d = redirectPc_q;
    holdInstr_d  = holdInstr_q;
    ifidInstr_d  = ifidInstr_q;
    ifidPc1_d    = ifidPc1_q;
    ifidValid_d  = ifidValid_q;
    doLoad       = 1'b0;
    loadWord     = imem_rdata;

    case (state_q)
      FETCH: begin
        if (flush) begin
          ifidValid_d = 1'b0;
          if (imem_ack) begin
            pc_d = next_pc;
          end else begin
            // The old request stays outstanding; its reply is dropped in DRAIN.
            redirectPc_d = next_pc;
            state_d      = DRAIN;
          end
        end else if (imem_ack) begin
          if (accept) begin
            doLoad = 1'b1;
          end else begin
            holdInstr_d = imem_rdata;
            state_d     = HOLD;
          end
        end else if (!stall) begin
          ifidValid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (flush || !stall) begin
          ifidValid_d = 1'b0;
        end
        if (imem_ack) begin
          pc_d    = flush ? next_pc : redirectPc_q;
          state_d = FETCH;
        end else if (flush) begin
          redirectPc_d = next_pc;
        end
      end
      HOLD: begin
        if (flush) begin
          ifidValid_d = 1'b0;
          pc_d        = next_pc;
          state_d     = FETCH;
        end else if (accept) begin
          doLoad   = 1'b1;
          loadWord = holdInstr_q;
        end
      end
      HALT: begin
        if (flush) begin
          ifidValid_d = 1'b0;
          pc_d        = next_pc;
          state_d     = FETCH;
        end else if (!stall) begin
          ifidValid_d = 1'b0;
        end
      end
      default: state_d = FETCH;
    endcase

    if (doLoad) begin
      ifidInstr_d = loadWord;
      ifidPc1_d   = pcPlus1;
      ifidValid_d = 1'b1;
      pc_d        = pcPlus1;
      state_d     = (loadWord[15:12] == HLT_OPCODE) ? HALT : FETCH;
    end
  end

  // Output logic. The request is forced low during the reset cycle.
  always_comb begin
    imem_req = !rst && ((state_q == FETCH) || (state_q == DRAIN));
    halted   = (state_q == HALT);
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ifid_instr = ifidInstr_q;
  assign ifid_pc1   = ifidPc1_q;
  assign ifid_valid = ifidValid_q;

`ifdef IF_PERF_EN
  logic        squashEvent;
  logic [15:0] perfFetch_q, perfSquash_q;

  // A fetched word is discarded when it returns alongside a flush, when it
  // returns in DRAIN, or when it is thrown away from HOLD.
  assign squashEvent = ((state_q == FETCH) && flush && imem_ack) ||
                       ((state_q == DRAIN) && imem_ack) ||
                       ((state_q == HOLD) && flush);

  // Performance counters. They wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      perfFetch_q  <= 16'h0000;
      perfSquash_q <= 16'h0000;
    end else begin
      if (doLoad)      perfFetch_q  <= perfFetch_q + 16'd1;
      if (squashEvent) perfSquash_q <= perfSquash_q + 16'd1;
    end
  end

  assign perf_fetch_cnt  = perfFetch_q;
  assign perf_squash_cnt = perfSquash_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage.
// The memory model returns 16'h1000+addr, with an optional HLT word at
// address 3, and acks after a programmable number of wait cycles. A second
// instance with RESET_PC=16'hFFFF covers PC wrap-around.

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] next_pc;
  logic        flush;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc1;
  logic        ifid_valid;
  logic [15:0] pc;
  logic        halted;
`ifdef IF_PERF_EN
  logic [15:0] perfFetch, perfSquash;
  logic [15:0] perfFetchW, perfSquashW;
`endif

  logic        rstW;
  logic        reqW;
  logic [15:0] addrW;
  logic [15:0] rdataW;
  logic [15:0] instrW;
  logic [15:0] pc1W;
  logic        validW;
  logic [15:0] pcW;
  logic        haltedW;

  int checks = 0;
  int errors = 0;
  int memLat = 0;
  int waitCnt = 0;
  logic hltEn = 1'b0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .next_pc(next_pc), .flush(flush), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .ifid_instr(ifid_instr), .ifid_pc1(ifid_pc1),
    .ifid_valid(ifid_valid), .pc(pc), .halted(halted)
`ifdef IF_PERF_EN
    , .perf_fetch_cnt(perfFetch), .perf_squash_cnt(perfSquash)
`endif
  );

  fetch_stage #(.RESET_PC(16'hFFFF)) dutW (
    .clk(clk), .rst(rstW), .next_pc(16'h0000), .flush(1'b0), .stall(1'b0),
    .imem_req(reqW), .imem_addr(addrW), .imem_rdata(rdataW),
    .imem_ack(reqW), .ifid_instr(instrW), .ifid_pc1(pc1W),
    .ifid_valid(validW), .pc(pcW), .halted(haltedW)
`ifdef IF_PERF_EN
    , .perf_fetch_cnt(perfFetchW), .perf_squash_cnt(perfSquashW)
`endif
  );

  // Memory model: ack arrives once the request has waited memLat cycles.
  assign imem_ack   = imem_req && (waitCnt >= memLat);
  assign imem_rdata = (hltEn && imem_addr == 16'h0003) ? 16'hF000 : 16'h1000 + imem_addr;
  assign rdataW     = 16'h1000 + addrW;

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) waitCnt <= 0;
    else                              waitCnt <= waitCnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1: rst just dropped, first request visible.
  task automatic doReset;
    rst = 1'b1; flush = 1'b0; stall = 1'b0; next_pc = 16'h0000;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rstW = 1'b1; flush = 1'b0; stall = 1'b0; next_pc = 16'h0000;
    tick; tick;
    checks++; if (pc !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pc got %h exp 0000", pc); end
    checks++; if (ifid_instr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_instr got %h exp 0000", ifid_instr); end
    checks++; if (ifid_pc1 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pc1 got %h exp 0000", ifid_pc1); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", ifid_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted got %b exp 0", halted); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b exp 0", imem_req); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++; $display("[TB] FAIL first_req got req=%b addr=%h exp req=1 addr=0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream;
    for (int i = 0; i < 6; i++) begin
      tick;
      checks++;
      if (ifid_instr !== 16'h1000 + 16'(i) || ifid_pc1 !== 16'(i + 1) || ifid_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stream%0d got instr=%h pc1=%h v=%b exp instr=%h pc1=%h v=1",
                 i, ifid_instr, ifid_pc1, ifid_valid, 16'h1000 + 16'(i), 16'(i + 1));
      end
    end
  endtask

  task automatic test_flush;
    flush = 1'b1; next_pc = 16'h0040;
    tick;
    flush = 1'b0;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %b exp 0", ifid_valid); end
    checks++; if (imem_addr !== 16'h0040) begin errors++; $display("[TB] FAIL flush_addr got %h exp 0040", imem_addr); end
    tick;
    checks++; if (ifid_instr !== 16'h1040 || ifid_pc1 !== 16'h0041 || ifid_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_target got instr=%h pc1=%h v=%b exp 1040 0041 1", ifid_instr, ifid_pc1, ifid_valid);
    end
  endtask

  task automatic test_drain;
    bit seen;
    memLat = 2;
    doReset;
    tick;                              // cycle 2, still waiting on addr 0
    flush = 1'b1; next_pc = 16'h0020;
    tick;                              // DRAIN, ack due this cycle
    flush = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || ifid_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL drain_hold got req=%b addr=%h v=%b exp 1 0000 0", imem_req, imem_addr, ifid_valid);
    end
    tick;
    checks++; if (imem_addr !== 16'h0020 || ifid_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL drain_redirect got addr=%h v=%b exp 0020 0", imem_addr, ifid_valid);
    end
`ifdef IF_PERF_EN
    checks++; if (perfSquash !== 16'd1) begin errors++; $display("[TB] FAIL drain_squash_cnt got %0d exp 1", perfSquash); end
`endif
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick;
      if (ifid_valid) seen = 1'b1;
    end
    checks++; if (!seen || ifid_instr !== 16'h1020 || ifid_pc1 !== 16'h0021) begin
      errors++; $display("[TB] FAIL drain_next got seen=%b instr=%h pc1=%h exp 1 1020 0021", seen, ifid_instr, ifid_pc1);
    end
    memLat = 0;
  endtask

  task automatic test_stall_hold;
    doReset;
    tick;                              // cycle 2: 1000 in IF/ID, ack of 1001 arriving
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (ifid_instr !== 16'h1000 || ifid_valid !== 1'b1 || imem_req !== 1'b0 || pc !== 16'h0001) begin
        errors++;
        $display("[TB] FAIL stall%0d got instr=%h v=%b req=%b pc=%h exp 1000 1 0 0001", i, ifid_instr, ifid_valid, imem_req, pc);
      end
    end
    stall = 1'b0;
    tick;
    checks++; if (ifid_instr !== 16'h1001 || ifid_pc1 !== 16'h0002 || imem_req !== 1'b1 || imem_addr !== 16'h0002) begin
      errors++; $display("[TB] FAIL hold_release got instr=%h pc1=%h req=%b addr=%h exp 1001 0002 1 0002",
                         ifid_instr, ifid_pc1, imem_req, imem_addr);
    end
    tick;
    checks++; if (ifid_instr !== 16'h1002 || ifid_pc1 !== 16'h0003) begin
      errors++; $display("[TB] FAIL hold_next got instr=%h pc1=%h exp 1002 0003", ifid_instr, ifid_pc1);
    end
  endtask

  task automatic test_flush_over_stall;
    doReset;
    tick;
    stall = 1'b1;
    tick;                              // HOLD with 1001 parked
    flush = 1'b1; next_pc = 16'h0030;
    tick;
    flush = 1'b0; stall = 1'b0;
    checks++; if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0030) begin
      errors++; $display("[TB] FAIL hold_flush got v=%b req=%b addr=%h exp 0 1 0030", ifid_valid, imem_req, imem_addr);
    end
    tick;
    checks++; if (ifid_instr !== 16'h1030 || ifid_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL hold_flush_next got instr=%h v=%b exp 1030 1", ifid_instr, ifid_valid);
    end
`ifdef IF_PERF_EN
    checks++; if (perfSquash !== 16'd1 || perfFetch !== 16'd2) begin
      errors++; $display("[TB] FAIL hold_perf got squash=%0d fetch=%0d exp 1 2", perfSquash, perfFetch);
    end
`endif
  endtask

  task automatic test_halt;
    hltEn = 1'b1;
    doReset;
    tick; tick; tick; tick;            // 1000, 1001, 1002, F000
    checks++; if (ifid_instr !== 16'hF000 || halted !== 1'b1 || pc !== 16'h0004) begin
      errors++; $display("[TB] FAIL halt_enter got instr=%h halted=%b pc=%h exp F000 1 0004", ifid_instr, halted, pc);
    end
    for (int i = 0; i < 20; i++) begin
      tick;
      checks++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 16'h0004) begin
        errors++; $display("[TB] FAIL halt_hold%0d got halted=%b req=%b pc=%h exp 1 0 0004", i, halted, imem_req, pc);
      end
    end
    flush = 1'b1; next_pc = 16'h0010;
    tick;
    flush = 1'b0;
    checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0010 || ifid_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL halt_resume got halted=%b req=%b addr=%h v=%b exp 0 1 0010 0",
                         halted, imem_req, imem_addr, ifid_valid);
    end
    tick;
    checks++; if (ifid_instr !== 16'h1010 || ifid_pc1 !== 16'h0011 || ifid_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL halt_resume_instr got instr=%h pc1=%h v=%b exp 1010 0011 1", ifid_instr, ifid_pc1, ifid_valid);
    end
    hltEn = 1'b0;
  endtask

  task automatic test_wrap;
    tick;
    rstW = 1'b0;
    #1;
    checks++; if (reqW !== 1'b1 || addrW !== 16'hFFFF) begin
      errors++; $display("[TB] FAIL wrap_first got req=%b addr=%h exp 1 FFFF", reqW, addrW);
    end
    tick;
    checks++; if (instrW !== 16'h0FFF || pc1W !== 16'h0000 || addrW !== 16'h0000) begin
      errors++; $display("[TB] FAIL wrap_pc1 got instr=%h pc1=%h addr=%h exp 0FFF 0000 0000", instrW, pc1W, addrW);
    end
    tick;
    checks++; if (instrW !== 16'h1000 || pc1W !== 16'h0001 || validW !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap_next got instr=%h pc1=%h v=%b exp 1000 0001 1", instrW, pc1W, validW);
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_flush;
    test_drain;
    test_stall_hold;
    test_flush_over_stall;
    test_halt;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
